// File: rtl/ppi_bus_sequencer_pkg.sv
// Shared types and constants for the PPI8255A bus sequencer.
// Exports: seqState_t (FSM states), phaseCnt_t (phase down-counter),
//          ppiOp_t (latched bus operation), CTRL_ADDR, MODE_FLAG_BIT, phaseLoad().
package ppi_bus_sequencer_pkg;

    localparam int unsigned PHASE_CNT_W   = 4;
    localparam logic [1:0]  CTRL_ADDR     = 2'b11;
    localparam int unsigned MODE_FLAG_BIT = 7;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } seqState_t;

    typedef logic [PHASE_CNT_W-1:0] phaseCnt_t;

    // One bus operation as latched at grant (or at init).
    typedef struct packed {
        logic       isWr;
        logic       isInit;
        logic [1:0] addr;
        logic [7:0] data;
    } ppiOp_t;

    // Counter value that makes a phase last 'clocks' cycles when counting down to zero.
    function automatic phaseCnt_t phaseLoad(input int unsigned clocks);
        return PHASE_CNT_W'(clocks - 1);
    endfunction

endpackage

// File: rtl/ppi_rr_arbiter.sv
// Round-robin arbiter for the PPI bus sequencer.
// Ports: Clk/Reset (sync, active-high), enable (grant allowed this clock),
//        req (request vector), grantValid_c/grantIdx_c (combinational winner).
// The last-grant pointer advances only when a grant is actually issued.
module ppi_rr_arbiter
    import ppi_bus_sequencer_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             enable,
    input  logic [NREQ-1:0]  req,
    output logic             grantValid_c,
    output logic [IDX_W-1:0] grantIdx_c
);

    logic [IDX_W-1:0] lastGrant;

    // Search starts one past the previous winner and wraps.
    always_comb begin
        grantValid_c = 1'b0;
        grantIdx_c   = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (enable && !grantValid_c && req[i] &&
                    ((32'(lastGrant) + off) % NREQ) == i) begin
                    grantValid_c = 1'b1;
                    grantIdx_c   = IDX_W'(i);
                end
            end
        end
    end

    // Reset to NREQ-1 so requester 0 has first priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lastGrant <= IDX_W'(NREQ - 1);
        end else if (grantValid_c) begin
            lastGrant <= grantIdx_c;
        end
    end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// Bus master for the PPI8255A host interface.
// After reset writes CFG_WORD to the control register, then serves NREQ
// requesters round-robin, each as one setup/strobe/hold bus cycle.
// Ports: Clk/Reset (sync, active-high); req/req_wr/req_addr/req_wdata (requester side);
//        ack/rdata/busy/init_done/cfg_shadow (status); nCs/nRe/nWr/A/d_out/d_oe/d_in (PPI pins).
// All outputs are registered.
module ppi_bus_sequencer
    import ppi_bus_sequencer_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter logic [7:0]  CFG_WORD = 8'h80,
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 3,
    parameter int unsigned T_HOLD   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [2*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              init_done,
    output logic [7:0]        cfg_shadow,
    output logic              nCs,
    output logic              nRe,
    output logic              nWr,
    output logic [1:0]        A,
    output logic [7:0]        d_out,
    output logic              d_oe,
    input  logic [7:0]        d_in
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    seqState_t        state, stateNext;
    phaseCnt_t        phaseCnt, phaseCntNext;
    ppiOp_t           op, opNext;
    logic [IDX_W-1:0] opGrant, opGrantNext;
    logic [7:0]       readBuf, readBufNext;

    logic [NREQ-1:0]  ackNext;
    logic [7:0]       rdataNext, cfgShadowNext, dOutNext;
    logic             busyNext, initDoneNext, nCsNext, nReNext, nWrNext, dOeNext;
    logic [1:0]       aNext;

    logic             grantValid_c;
    logic [IDX_W-1:0] grantIdx_c;
    ppiOp_t           reqOp_c;
    logic             startCycle_c;
    ppiOp_t           startOp_c;

    ppi_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arbiter (
        .Clk          (Clk),
        .Reset        (Reset),
        .enable       ((state == ST_IDLE) && init_done),
        .req          (req),
        .grantValid_c (grantValid_c),
        .grantIdx_c   (grantIdx_c)
    );

    // Winner's request fields.
    always_comb begin
        reqOp_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grantIdx_c == IDX_W'(i)) begin
                reqOp_c.isWr = req_wr[i];
                reqOp_c.addr = req_addr[2*i +: 2];
                reqOp_c.data = req_wdata[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext     = state;
        phaseCntNext  = phaseCnt;
        opNext        = op;
        opGrantNext   = opGrant;
        readBufNext   = readBuf;
        ackNext       = '0;
        rdataNext     = rdata;
        busyNext      = busy;
        initDoneNext  = init_done;
        cfgShadowNext = cfg_shadow;
        nCsNext       = nCs;
        nReNext       = nRe;
        nWrNext       = nWr;
        aNext         = A;
        dOutNext      = d_out;
        dOeNext       = d_oe;
        startCycle_c  = 1'b0;
        startOp_c     = '0;

        case (state)
            ST_INIT: begin
                startCycle_c     = 1'b1;
                startOp_c.isWr   = 1'b1;
                startOp_c.isInit = 1'b1;
                startOp_c.addr   = CTRL_ADDR;
                startOp_c.data   = CFG_WORD;
            end
            ST_IDLE: begin
                if (grantValid_c) begin
                    startCycle_c = 1'b1;
                    startOp_c    = reqOp_c;
                    opGrantNext  = grantIdx_c;
                end
            end
            ST_SETUP: begin
                if (phaseCnt == '0) begin
                    stateNext    = ST_STROBE;
                    phaseCntNext = phaseLoad(T_STROBE);
                    nWrNext      = ~op.isWr;
                    nReNext      = op.isWr;
                end else begin
                    phaseCntNext = phaseCnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (phaseCnt == '0) begin
                    stateNext    = ST_HOLD;
                    phaseCntNext = phaseLoad(T_HOLD);
                    nWrNext      = 1'b1;
                    nReNext      = 1'b1;
                    readBufNext  = d_in;
                end else begin
                    phaseCntNext = phaseCnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (phaseCnt == '0) begin
                    stateNext = ST_DONE;
                    nCsNext   = 1'b1;
                    dOeNext   = 1'b0;
                    if (op.isWr && op.addr == CTRL_ADDR && op.data[MODE_FLAG_BIT]) begin
                        cfgShadowNext = op.data;
                    end
                    if (!op.isWr) begin
                        rdataNext = readBuf;
                    end
                    if (op.isInit) begin
                        initDoneNext = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NREQ; i++) begin
                            if (opGrant == IDX_W'(i)) begin
                                ackNext[i] = 1'b1;
                            end
                        end
                    end
                end else begin
                    phaseCntNext = phaseCnt - 1'b1;
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
                busyNext  = 1'b0;
            end
            default: begin
                stateNext = ST_INIT;
            end
        endcase

        // Common entry into SETUP for both the init write and granted requests.
        if (startCycle_c) begin
            stateNext    = ST_SETUP;
            phaseCntNext = phaseLoad(T_SETUP);
            opNext       = startOp_c;
            busyNext     = 1'b1;
            nCsNext      = 1'b0;
            aNext        = startOp_c.addr;
            dOeNext      = startOp_c.isWr;
            if (startOp_c.isWr) begin
                dOutNext = startOp_c.data;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_INIT;
            phaseCnt   <= '0;
            op         <= '0;
            opGrant    <= '0;
            readBuf    <= '0;
            ack        <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            cfg_shadow <= '0;
            nCs        <= 1'b1;
            nRe        <= 1'b1;
            nWr        <= 1'b1;
            A          <= '0;
            d_out      <= '0;
            d_oe       <= 1'b0;
        end else begin
            state      <= stateNext;
            phaseCnt   <= phaseCntNext;
            op         <= opNext;
            opGrant    <= opGrantNext;
            readBuf    <= readBufNext;
            ack        <= ackNext;
            rdata      <= rdataNext;
            busy       <= busyNext;
            init_done  <= initDoneNext;
            cfg_shadow <= cfgShadowNext;
            nCs        <= nCsNext;
            nRe        <= nReNext;
            nWr        <= nWrNext;
            A          <= aNext;
            d_out      <= dOutNext;
            d_oe       <= dOeNext;
        end
    end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Self-checking bench for ppi_bus_sequencer: directed and random requester traffic
// compared against a transaction-level model of grants, bus timing and status outputs.
module tb_ppi_bus_sequencer;

    localparam int         NREQ     = 2;
    localparam logic [7:0] CFG_WORD = 8'h80;
    localparam int         T_SETUP  = 2;
    localparam int         T_STROBE = 3;
    localparam int         T_HOLD   = 1;

    logic                Clk       = 1'b0;
    logic                Reset     = 1'b1;
    logic [NREQ-1:0]     req       = '0;
    logic [NREQ-1:0]     req_wr    = '0;
    logic [2*NREQ-1:0]   req_addr  = '0;
    logic [8*NREQ-1:0]   req_wdata = '0;
    logic [7:0]          d_in      = '0;
    logic [NREQ-1:0]     ack;
    logic [7:0]          rdata;
    logic                busy;
    logic                init_done;
    logic [7:0]          cfg_shadow;
    logic                nCs;
    logic                nRe;
    logic                nWr;
    logic [1:0]          A;
    logic [7:0]          d_out;
    logic                d_oe;

    ppi_bus_sequencer #(
        .NREQ     (NREQ),
        .CFG_WORD (CFG_WORD),
        .T_SETUP  (T_SETUP),
        .T_STROBE (T_STROBE),
        .T_HOLD   (T_HOLD)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req        (req),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .rdata      (rdata),
        .busy       (busy),
        .init_done  (init_done),
        .cfg_shadow (cfg_shadow),
        .nCs        (nCs),
        .nRe        (nRe),
        .nWr        (nWr),
        .A          (A),
        .d_out      (d_out),
        .d_oe       (d_oe),
        .d_in       (d_in)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs as presented at the upcoming rising edge.
    logic [NREQ-1:0]   reqSeen;
    logic [NREQ-1:0]   wrSeen;
    logic [2*NREQ-1:0] addrSeen;
    logic [8*NREQ-1:0] dataSeen;
    logic              resetSeen;

    // Reference model state.
    int         lastGrantM  = NREQ - 1;
    bit         expectInit  = 1'b1;
    bit         initDoneM   = 1'b0;
    logic [7:0] shadowM     = '0;
    logic [7:0] rdataM      = '0;
    bit         inCycle     = 1'b0;
    int         curIdx      = -1;
    bit         curWr;
    logic [1:0] curAddr;
    logic [7:0] curData;
    logic [7:0] readVal;
    int         lowCnt, strobeCnt, strobeStart;
    int         highRun     = 0;

    // Requester driver state.
    bit pend[NREQ];
    bit granted[NREQ];
    int delayCnt[NREQ];
    bit autoMode   = 1'b0;
    int maxDelay   = 0;
    bit allowDrop  = 1'b0;
    int forcedRead = -1;

    function automatic bit anyOutstanding();
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i] || granted[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic monitor();
        bit strobeLow;
        int w;
        if (resetSeen) begin
            checkEq("rst_nCs", nCs, 1);
            checkEq("rst_strobes", {nRe, nWr}, 2'b11);
            checkEq("rst_A", A, 0);
            checkEq("rst_d_out", d_out, 0);
            checkEq("rst_d_oe", d_oe, 0);
            checkEq("rst_ack", ack, 0);
            checkEq("rst_rdata", rdata, 0);
            checkEq("rst_busy", busy, 0);
            checkEq("rst_init_done", init_done, 0);
            checkEq("rst_cfg_shadow", cfg_shadow, 0);
            lastGrantM = NREQ - 1;
            expectInit = 1'b1;
            initDoneM  = 1'b0;
            shadowM    = '0;
            rdataM     = '0;
            inCycle    = 1'b0;
            highRun    = 1;
            for (int i = 0; i < NREQ; i++) begin
                pend[i]     = 1'b0;
                granted[i]  = 1'b0;
                delayCnt[i] = 0;
            end
            req = '0;
            return;
        end

        if (!nCs) begin
            if (!inCycle) begin
                inCycle     = 1'b1;
                lowCnt      = 0;
                strobeCnt   = 0;
                strobeStart = 0;
                checkEq("cs_gap", highRun >= 1, 1);
                if (expectInit) begin
                    curIdx  = -1;
                    curWr   = 1'b1;
                    curAddr = 2'b11;
                    curData = CFG_WORD;
                end else begin
                    w = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        if (w < 0 && reqSeen[(lastGrantM + k) % NREQ]) w = (lastGrantM + k) % NREQ;
                    end
                    checkEq("grant_found", w >= 0, 1);
                    if (w < 0) w = 0;
                    curIdx     = w;
                    lastGrantM = w;
                    curWr      = wrSeen[w];
                    curAddr    = addrSeen[2*w +: 2];
                    curData    = dataSeen[8*w +: 8];
                    pend[w]    = 1'b0;
                    granted[w] = 1'b1;
                    // Fields after grant must be ignored by the DUT.
                    req_wr[w]           = 1'($urandom);
                    req_addr[2*w +: 2]  = 2'($urandom);
                    req_wdata[8*w +: 8] = 8'($urandom);
                    if (allowDrop && $urandom_range(3) == 0) req[w] = 1'b0;
                end
                readVal = (forcedRead >= 0) ? 8'(forcedRead) : 8'($urandom);
            end
            lowCnt++;
            strobeLow = curWr ? !nWr : !nRe;
            if (curWr) checkEq("nRe_during_write", nRe, 1);
            else       checkEq("nWr_during_read", nWr, 1);
            if (strobeLow) begin
                if (strobeCnt == 0) strobeStart = lowCnt;
                strobeCnt++;
            end
            checkEq("A", A, curAddr);
            checkEq("d_oe", d_oe, curWr);
            if (curWr) checkEq("d_out", d_out, curData);
            checkEq("busy", busy, 1);
            checkEq("ack_quiet", ack, 0);
            // Valid read data only on the final strobe clock.
            d_in = (!curWr && strobeLow && strobeCnt == T_STROBE) ? readVal : 8'($urandom);
        end else begin
            checkEq("strobes_cs_high", {nRe, nWr}, 2'b11);
            if (inCycle) begin
                inCycle = 1'b0;
                highRun = 0;
                checkEq("cs_len", lowCnt, T_SETUP + T_STROBE + T_HOLD);
                checkEq("strobe_start", strobeStart, T_SETUP + 1);
                checkEq("strobe_len", strobeCnt, T_STROBE);
                checkEq("d_oe_done", d_oe, 0);
                if (curWr && curAddr == 2'b11 && curData[7]) shadowM = curData;
                if (!curWr) rdataM = readVal;
                if (curIdx < 0) begin
                    checkEq("ack_init", ack, 0);
                    initDoneM  = 1'b1;
                    expectInit = 1'b0;
                end else begin
                    checkEq("ack", ack, 1 << curIdx);
                    granted[curIdx]  = 1'b0;
                    req[curIdx]      = 1'b0;
                    delayCnt[curIdx] = (maxDelay > 0) ? int'($urandom_range(maxDelay)) : 0;
                end
            end else begin
                checkEq("ack_quiet", ack, 0);
                checkEq("busy_idle", busy, 0);
            end
            highRun++;
            d_in = 8'($urandom);
        end
        checkEq("init_done", init_done, initDoneM);
        checkEq("cfg_shadow", cfg_shadow, shadowM);
        checkEq("rdata", rdata, rdataM);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (autoMode && !pend[i] && !granted[i]) begin
                if (delayCnt[i] > 0) begin
                    delayCnt[i]--;
                end else begin
                    pend[i]             = 1'b1;
                    req[i]              = 1'b1;
                    req_wr[i]           = 1'($urandom);
                    req_addr[2*i +: 2]  = 2'($urandom);
                    req_wdata[8*i +: 8] = 8'($urandom);
                end
            end
        end
    endtask

    task automatic step();
        reqSeen   = req;
        wrSeen    = req_wr;
        addrSeen  = req_addr;
        dataSeen  = req_wdata;
        resetSeen = Reset;
        @(negedge Clk);
        monitor();
        drive();
    endtask

    task automatic doReq(input int i, input bit wr, input logic [1:0] addr, input logic [7:0] data);
        int n;
        n = 0;
        req_wr[i]           = wr;
        req_addr[2*i +: 2]  = addr;
        req_wdata[8*i +: 8] = data;
        req[i]              = 1'b1;
        pend[i]             = 1'b1;
        while ((pend[i] || granted[i]) && n < 60) begin
            step();
            n++;
        end
        checkEq("req_timeout", pend[i] || granted[i], 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        autoMode = 1'b0;
        while (anyOutstanding() && n < 200) begin
            step();
            n++;
        end
        checkEq("drain_timeout", anyOutstanding(), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]     = 1'b0;
            granted[i]  = 1'b0;
            delayCnt[i] = 0;
        end

        // Reset, then the init write of CFG_WORD.
        Reset = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        n = 0;
        while (!initDoneM && n < 30) begin
            step();
            n++;
        end
        checkEq("init_seen", initDoneM, 1);
        checkEq("init_shadow", cfg_shadow, 8'h80);

        // Directed write and read.
        doReq(0, 1'b1, 2'd0, 8'h5A);
        forcedRead = 8'hC3;
        doReq(1, 1'b0, 2'd1, 8'h00);
        forcedRead = -1;
        checkEq("rdata_C3", rdata, 8'hC3);

        // Both requesters held continuously.
        autoMode  = 1'b1;
        maxDelay  = 0;
        allowDrop = 1'b0;
        repeat (40) step();
        drain();

        // Bit set/reset write leaves the shadow alone; a mode word updates it.
        doReq(1, 1'b1, 2'd3, CFG_WORD);
        doReq(0, 1'b1, 2'd3, 8'h07);
        checkEq("shadow_bsr", cfg_shadow, 8'h80);
        doReq(1, 1'b1, 2'd3, 8'h9B);
        checkEq("shadow_mode", cfg_shadow, 8'h9B);

        // Random traffic with mid-cycle request drops.
        autoMode  = 1'b1;
        maxDelay  = 3;
        allowDrop = 1'b1;
        repeat (400) step();
        drain();
        allowDrop = 1'b0;

        // Reset during the strobe of a write.
        req_wr[0]       = 1'b1;
        req_addr[1:0]   = 2'd2;
        req_wdata[7:0]  = 8'h3C;
        req[0]          = 1'b1;
        pend[0]         = 1'b1;
        n = 0;
        while (nWr !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        checkEq("strobe_reached", nWr, 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        doReq(0, 1'b1, 2'd2, 8'h3C);
        checkEq("post_reset_init", init_done, 1);
        checkEq("post_reset_shadow", cfg_shadow, 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
